// File: rtl/ad_ddr_wr_sched.sv
// DDR write scheduler: drains a FIFO in fixed-length bursts into a ring buffer,
// alternating FIFO fetch and DDR beat so each beat's data is registered before issue.
module ad_ddr_wr_sched #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 25,
  parameter int BUF_BASE  = 0,
  parameter int BUF_WORDS = 65536
) (
  input  logic              ddr_clk,
  input  logic              reset_syn,
  input  logic              enable,
  input  logic [9:0]        fifo_usedw,
  input  logic [31:0]       fifo_q,
  input  logic              full,
  output logic              rd_fifo_req,
  output logic              ddr_write,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [6:0]        ddr_burstcnt,
  output logic [31:0]       ddr_wdata,
  input  logic              ddr_waitreq,
  output logic              busy,
  output logic              wrap,
  output logic              overflow,
  output logic [31:0]       words_written
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, WRITE} state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BUF_BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_BASE + BUF_WORDS - BURST_LEN);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);
  localparam logic [6:0]        LAST_BEAT = 7'(BURST_LEN - 1);
  localparam logic [9:0]        THRESH    = 10'(BURST_LEN);

  state_t     state, state_nxt;
  logic [6:0] beat;
  logic       accept;
  logic       last_beat;

  assign ddr_burstcnt = 7'(BURST_LEN);
  assign accept       = ddr_write && !ddr_waitreq;
  assign last_beat    = (beat == LAST_BEAT);

  always_ff @(posedge ddr_clk) begin
    if (reset_syn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable && fifo_usedw >= THRESH) state_nxt = FETCH;
      FETCH: state_nxt = LOAD;
      LOAD:  state_nxt = WRITE;
      WRITE: if (!ddr_waitreq) state_nxt = last_beat ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // The read for beat n+1 is issued as beat n is accepted, so LOAD always sees fresh fifo_q.
  always_comb begin
    rd_fifo_req = 1'b0;
    ddr_write   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      FETCH: rd_fifo_req = 1'b1;
      WRITE: begin
        ddr_write   = 1'b1;
        rd_fifo_req = !ddr_waitreq && !last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ddr_clk) begin
    if (reset_syn) begin
      ddr_addr      <= BASE_ADDR;
      ddr_wdata     <= '0;
      beat          <= '0;
      words_written <= '0;
      wrap          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (full) overflow <= 1'b1;
      if (state == LOAD) ddr_wdata <= fifo_q;
      if (accept) begin
        words_written <= words_written + 32'd1;
        if (last_beat) begin
          beat <= '0;
          if (ddr_addr == LAST_ADDR) begin
            ddr_addr <= BASE_ADDR;
            wrap     <= 1'b1;
          end else begin
            ddr_addr <= ddr_addr + STEP;
          end
        end else begin
          beat <= beat + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ad_ddr_wr_sched.sv
// Bench for ad_ddr_wr_sched: FIFO responder, scoreboard of read words vs beats,
// and directed bursts covering stall, threshold, wrap, enable drop, reset and overflow.
module tb_ad_ddr_wr_sched;
  localparam int BL = 16, AW = 25, BASE = 0, WORDS = 32;
  localparam logic [AW-1:0] END_ADDR = AW'(BASE + WORDS - BL);

  logic          ddr_clk = 1'b0, reset_syn = 1'b1, enable = 1'b0, full = 1'b0, ddr_waitreq = 1'b0;
  logic [9:0]    fifo_usedw = '0;
  logic [31:0]   fifo_q = '0;
  logic          rd_fifo_req, ddr_write, busy, wrap, overflow;
  logic [AW-1:0] ddr_addr;
  logic [6:0]    ddr_burstcnt;
  logic [31:0]   ddr_wdata, words_written;

  int total = 0, bad = 0;

  ad_ddr_wr_sched #(.BURST_LEN(BL), .ADDR_W(AW), .BUF_BASE(BASE), .BUF_WORDS(WORDS)) dut (
    .ddr_clk(ddr_clk), .reset_syn(reset_syn), .enable(enable), .fifo_usedw(fifo_usedw),
    .fifo_q(fifo_q), .full(full), .rd_fifo_req(rd_fifo_req), .ddr_write(ddr_write),
    .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt), .ddr_wdata(ddr_wdata),
    .ddr_waitreq(ddr_waitreq), .busy(busy), .wrap(wrap), .overflow(overflow),
    .words_written(words_written)
  );

  initial forever #5 ddr_clk = ~ddr_clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  // FIFO: each read yields the next integer, one cycle after the strobe
  int fifo_word = 0;
  always @(posedge ddr_clk) begin
    if (rd_fifo_req) begin
      fifo_q    <= fifo_word;
      fifo_word <= fifo_word + 1;
    end
  end

  // Model: queue of words read, burst base address, accepted-beat count, sticky overflow
  logic [31:0]   rdq[$];
  int            rd_seq = 0, m_beat = 0, m_rds = 0;
  logic [31:0]   m_words = '0;
  logic [AW-1:0] m_addr = '0;
  logic          m_wrap = 1'b0, m_ovf = 1'b0, mon_on = 1'b0;
  logic          p_stall = 1'b0;
  logic [31:0]   p_data = '0;
  logic [AW-1:0] p_addr = '0;

  always @(negedge ddr_clk) begin
    if (mon_on) begin
      chk("words", words_written, m_words);
      chk("wrap", wrap, m_wrap);
      chk("overflow", overflow, m_ovf);
      chk("burstcnt", ddr_burstcnt, BL);
      chk("write_not_busy", ddr_write & ~busy, 0);
      chk("rd_not_busy", rd_fifo_req & ~busy, 0);
      chk("rd_on_stall", rd_fifo_req & ddr_write & ddr_waitreq, 0);
      if (!busy) chk("idle_addr", ddr_addr, m_addr);
      if (p_stall) begin
        chk("hold_write", ddr_write, 1);
        chk("hold_data", ddr_wdata, p_data);
        chk("hold_addr", ddr_addr, p_addr);
      end
      if (ddr_write && !ddr_waitreq) begin
        if (rdq.size() == 0) chk("beat_without_read", 1, 0);
        else chk("wdata", ddr_wdata, rdq.pop_front());
        chk("beat_addr", ddr_addr, m_addr);
      end
    end
    if (rd_fifo_req) begin
      rdq.push_back(rd_seq);
      rd_seq++;
      m_rds++;
    end
    p_stall = ddr_write && ddr_waitreq;
    p_data  = ddr_wdata;
    p_addr  = ddr_addr;
    m_wrap  = 1'b0;
    m_ovf   = m_ovf | full;
    if (ddr_write && !ddr_waitreq) begin
      m_words++;
      m_beat++;
      if (m_beat == BL) begin
        if (mon_on) chk("burst_reads", m_rds, BL);
        m_beat = 0;
        m_rds  = 0;
        if (m_addr == END_ADDR) begin
          m_addr = AW'(BASE);
          m_wrap = 1'b1;
        end else begin
          m_addr = m_addr + AW'(BL);
        end
      end
    end
    if (reset_syn) begin
      m_words = '0; m_addr = AW'(BASE); m_wrap = 1'b0; m_ovf = 1'b0;
      m_beat = 0; m_rds = 0; rdq.delete(); p_stall = 1'b0; mon_on = 1'b1;
    end
  end

  // Runs one burst from the current point (#1 after an edge); negative knobs disable a feature
  task automatic do_burst(input int stall_beat, input int stall_n, input int drop_beat,
                          input int rst_beat, output int beats, output int rds, output int busyc,
                          output int wrap_seen, output logic [31:0] f_addr,
                          output logic [31:0] f_data, output logic [31:0] l_data);
    int cyc = 0;
    int stall_left = stall_n;
    bit started = 0, done = 0;
    beats = 0; rds = 0; busyc = 0; wrap_seen = 0;
    f_addr = '1; f_data = '1; l_data = '1;
    fifo_usedw = 10'd16;
    enable = 1'b1;
    while (!done && cyc < 400) begin
      if (wrap) wrap_seen++;
      if (busy) begin
        started = 1;
        busyc++;
        fifo_usedw = '0;
        if (beats == drop_beat) enable = 1'b0;
        if (rst_beat >= 0 && beats == rst_beat) begin
          reset_syn = 1'b1;
          ddr_waitreq = 1'b0;
          @(posedge ddr_clk); #1;
          reset_syn = 1'b0;
          done = 1;
        end else begin
          if (ddr_write && beats == stall_beat && stall_left > 0) begin
            ddr_waitreq = 1'b1;
            stall_left--;
          end else begin
            ddr_waitreq = 1'b0;
          end
          if (rd_fifo_req) rds++;
          if (ddr_write && !ddr_waitreq) begin
            if (beats == 0) begin f_addr = 32'(ddr_addr); f_data = ddr_wdata; end
            l_data = ddr_wdata;
            beats++;
          end
        end
      end else if (started) begin
        done = 1;
      end
      if (!done) begin @(posedge ddr_clk); #1; cyc++; end
    end
    chk("burst_timeout", {31'b0, done}, 1);
    ddr_waitreq = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, bc, ws, viol;
    logic [31:0] fa, fd, ld;
    reset_syn = 1'b1;
    repeat (3) @(posedge ddr_clk);
    #1 reset_syn = 1'b0;
    chk("rst_write", ddr_write, 0);
    chk("rst_rd", rd_fifo_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", ddr_addr, BASE);
    chk("rst_wdata", ddr_wdata, 0);
    chk("rst_words", words_written, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_wrap", wrap, 0);

    // basic burst: words 0..15 at address 0, 33 busy cycles at full throughput
    do_burst(-1, 0, -1, -1, b, r, bc, ws, fa, fd, ld);
    chk("b1_beats", b, 16); chk("b1_reads", r, 16); chk("b1_busy", bc, 33);
    chk("b1_addr", fa, 0); chk("b1_first", fd, 0); chk("b1_last", ld, 15); chk("b1_wrap", ws, 0);
    chk("b1_words", words_written, 16); chk("b1_next_addr", ddr_addr, 16);

    // stall 5 cycles on beat 3; second burst ends at ring top and wraps
    do_burst(3, 5, -1, -1, b, r, bc, ws, fa, fd, ld);
    chk("b2_beats", b, 16); chk("b2_reads", r, 16); chk("b2_busy", bc, 38);
    chk("b2_addr", fa, 16); chk("b2_first", fd, 16); chk("b2_last", ld, 31); chk("b2_wrap", ws, 1);
    chk("b2_words", words_written, 32); chk("b2_next_addr", ddr_addr, 0);

    full = 1'b1;
    @(posedge ddr_clk); #1 full = 1'b0;
    chk("ovf_set", overflow, 1);

    // threshold: one word short holds off the burst
    fifo_usedw = 10'd15; enable = 1'b1; viol = 0;
    repeat (100) begin
      @(posedge ddr_clk); #1;
      if (busy || rd_fifo_req) viol++;
    end
    chk("thr_idle", viol, 0);
    fifo_usedw = 10'd16;
    @(posedge ddr_clk); #1;
    chk("thr_busy", busy, 1);
    chk("thr_fetch", rd_fifo_req, 1);
    do_burst(-1, 0, -1, -1, b, r, bc, ws, fa, fd, ld);
    chk("b3_beats", b, 16); chk("b3_reads", r, 16); chk("b3_busy", bc, 33);
    chk("b3_addr", fa, 0); chk("b3_first", fd, 32); chk("b3_wrap", ws, 0);

    // enable drop mid-burst: completes, then stays idle
    do_burst(-1, 0, 8, -1, b, r, bc, ws, fa, fd, ld);
    chk("b4_beats", b, 16); chk("b4_busy", bc, 33); chk("b4_addr", fa, 16); chk("b4_wrap", ws, 1);
    fifo_usedw = 10'd16; viol = 0;
    repeat (20) begin
      @(posedge ddr_clk); #1;
      if (busy) viol++;
    end
    chk("drop_idle", viol, 0);
    chk("ovf_sticky", overflow, 1);
    chk("b4_words", words_written, 64);

    // reset after 5 beats abandons the burst
    do_burst(-1, 0, -1, 5, b, r, bc, ws, fa, fd, ld);
    chk("b5_beats", b, 5); chk("b5_addr", fa, 0);
    chk("b5_rst_write", ddr_write, 0); chk("b5_rst_addr", ddr_addr, BASE);
    chk("b5_rst_words", words_written, 0); chk("b5_rst_ovf", overflow, 0);
    chk("b5_rst_busy", busy, 0);

    do_burst(-1, 0, -1, -1, b, r, bc, ws, fa, fd, ld);
    chk("b6_beats", b, 16); chk("b6_reads", r, 16); chk("b6_addr", fa, 0);
    chk("b6_words", words_written, 16);

    repeat (3) @(posedge ddr_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
